// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operations, immediate formats and result-mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BR,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_PC4       = 2'b11;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   imm_sel = IMM_S;
            OP_BR:   imm_sel = IMM_B;
            OP_JAL:  imm_sel = IMM_J;
            OP_LUI:  imm_sel = IMM_U;
            default: imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Purpose: maps funct3/funct7b5 to an ALU operation and flags unsupported funct3.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the FSM sits in an execute state.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    always_comb begin
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (funct3)
            // funct7b5 only selects sub for register-register ops; addi keeps bit 30 as immediate
            3'b000:  ALUControl = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  ALUControl = ALU_SLT;
            3'b110:  ALUControl = ALU_OR;
            3'b111:  ALUControl = ALU_AND;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle RV32I control FSM driving ALU, memory, regfile and PC; CTRL_PERF_EN adds perf counters.
// Latency: R/I/lui 4, lw 5, sw 4, branch/jal 3 cycles plus one per mem_ready-low cycle.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready; traps after WAIT_LIMIT stalled cycles.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic [2:0]  ALUControl,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic        RegWrite,
    output logic        PCUpdate,
    output logic        PCSrc,
    output logic        instr_retired,
    output logic        trap,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [2:0]    dec_alu;
    logic          dec_illegal;
    logic          in_wait;
    logic          wait_expire;

    alu_decoder u_alu_decoder (
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUControl (dec_alu),
        .illegal    (dec_illegal)
    );

    assign in_wait     = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign wait_expire = (WAIT_LIMIT != 0) && in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            if (WAIT_LIMIT != 0 && in_wait && !mem_ready && !wait_expire)
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;

            case (state)
                S_IDLE:     state <= S_FETCH;
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                            else if (wait_expire) state <= S_TRAP;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_LUI:       state <= S_LUI;
                        OP_BR:        state <= (funct3[2:1] == 2'b00) ? S_BR : S_TRAP;
                        OP_JAL:       state <= S_JAL;
                        default:      state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                            else if (wait_expire) state <= S_TRAP;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                            else if (wait_expire) state <= S_TRAP;
                S_EXECR,
                S_EXECI:    state <= dec_illegal ? S_TRAP : S_ALUWB;
                S_LUI:      state <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BR,
                S_JAL:      state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_TRAP;
            endcase
        end
    end

    // Outputs decode from state alone, except the strobes that must qualify on this cycle's handshake/Zero.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        ALUControl = ALU_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b0;
        PCUpdate   = 1'b0;
        PCSrc      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                IRWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 1'b1;
            end
            S_MEMADR:  ALUSrcB = 1'b1;
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                RegWrite  = 1'b1;
                PCUpdate  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                PCUpdate = mem_ready;
            end
            S_EXECR:   ALUControl = dec_alu;
            S_EXECI: begin
                ALUSrcB    = 1'b1;
                ALUControl = dec_alu;
            end
            S_LUI: begin
                ALUSrcB    = 1'b1;
                ALUControl = ALU_PASSB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                PCUpdate = 1'b1;
            end
            S_BR: begin
                ALUControl = ALU_SUB;
                PCUpdate   = 1'b1;
                PCSrc      = Zero ^ funct3[0];
            end
            S_JAL: begin
                ResultSrc = RES_PC4;
                RegWrite  = 1'b1;
                PCUpdate  = 1'b1;
                PCSrc     = 1'b1;
            end
            default: ;
        endcase
    end

    assign ImmSrc        = (state == S_IDLE) ? IMM_I : imm_sel(op);
    assign instr_retired = PCUpdate;
    assign trap          = (state == S_TRAP);

`ifdef CTRL_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] ret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state != S_IDLE && state != S_TRAP)
                cyc_q <= cyc_q + 32'd1;
            if (instr_retired)
                ret_q <= ret_q + 32'd1;
        end
    end

    assign cycle_count   = cyc_q;
    assign instret_count = ret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle RV32I core. It is the producer side of the ALU control interface: it drives ALUControl, ALUSrcA and ALUSrcB, and consumes Zero.
- It also sequences instruction fetch and data memory over a req/ready handshake, register writeback and PC update.
- The datapath owns IR, ALUOut (free-running, latched every cycle), the ReadData latch, the PC register and a dedicated PC+4 adder.

Parameters:
- WAIT_LIMIT, 16: consecutive cycles with mem_ready low in any memory-wait state before trapping; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  from ALU
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory request
- MemWrite  out  1  store qualifier on mem_req
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 pass SrcB
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  1  0 = RD2, 1 = ImmExt
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult, 11 PC+4
- RegWrite  out  1  register file write enable
- PCUpdate  out  1  PC load
- PCSrc  out  1  0 = PC+4, 1 = ALUOut
- instr_retired  out  1  pulse, equals PCUpdate
- trap  out  1  sticky fault
- cycle_count  out  32  see optional feature
- instret_count  out  32  see optional feature

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset: state = IDLE, wait counter = 0, trap = 0. All outputs are 0 while rst_n is low and in IDLE.
- IDLE always goes to FETCH on the next cycle.
- Default outputs in every state: ALUControl = 000, ALUSrcA = 0, ALUSrcB = 0, all enables 0. ImmSrc is always decoded combinationally from op: lw/addi group → I, sw → S, branch → B, jal → J, lui → U, else I.
- FETCH: mem_req = 1, AdrSrc = 0, IRWrite = mem_ready. Go to DECODE on mem_ready, else stay.
- DECODE: ALUSrcA = 1, ALUSrcB = 1, ALUControl = add, so ALUOut becomes the branch/jump target. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0110111 → LUI
  - 1100011 with funct3 000/001 → BR
  - 1101111 → JAL
  - anything else → TRAP
- MEMADR: ALUSrcB = 1, add. Go to MEMREAD if op is lw, else MEMWRITE.
- MEMREAD: mem_req = 1, AdrSrc = 1. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc = 01, RegWrite = 1, PCUpdate = 1, PCSrc = 0. Go to FETCH.
- MEMWRITE: mem_req = 1, MemWrite = 1, AdrSrc = 1. On mem_ready: PCUpdate = 1, PCSrc = 0, go to FETCH.
- EXECR: SrcA = RD1, SrcB = RD2, ALUControl decoded from funct3/funct7b5. Go to ALUWB.
- EXECI: ALUSrcB = 1, ALUControl decoded from funct3 only (funct7b5 ignored, never sub). Go to ALUWB.
- LUI: ALUSrcB = 1, ALUControl = 110. Go to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, PCUpdate = 1, PCSrc = 0. Go to FETCH.
- BR: ALUControl = sub, PCUpdate = 1, PCSrc = Zero XOR funct3[0] (beq/bne). Go to FETCH.
- JAL: ResultSrc = 11, RegWrite = 1, PCUpdate = 1, PCSrc = 1. Go to FETCH.
- ALU decode:
  - funct3 000 → add, or sub when the instruction is R-type and funct7b5 = 1
  - funct3 010 → slt
  - funct3 110 → or
  - funct3 111 → and
  - funct3 001, 011, 100, 101 → illegal; EXECR/EXECI go to TRAP instead of ALUWB, with no RegWrite.
- Latency with zero memory wait: R/I/lui 4 cycles, lw 5, sw 4, branch 3, jal 3. Each cycle of mem_ready low adds one cycle.
- Timeout: the wait counter increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready low, and clears on mem_ready or state exit. When it reaches WAIT_LIMIT (WAIT_LIMIT ≠ 0), go to TRAP.
- TRAP: trap = 1, all enables 0. Stays in TRAP until rst_n.
- Reset mid-operation: immediate return to IDLE, and any in-flight memory request is dropped.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined:
  - cycle_count increments every cycle not in IDLE or TRAP.
  - instret_count increments on instr_retired.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALU_ADD/SUB/AND/OR/SLT/PASSB encodings
  - IMM_* and RES_* encodings
- Sub-module alu_decoder: combinational; inputs op, funct3, funct7b5; outputs ALUControl and illegal.

Test Plan:
- Reset: rst_n low during MEMREAD → all outputs 0 asynchronously; after release, IDLE then mem_req = 1 in FETCH on the second cycle.
- add (op 0110011, f3 000, f7b5 0), mem_ready = 1 → EXECR drives ALUControl 000 with ALUSrcA/B = 0; ALUWB drives RegWrite = 1, ResultSrc = 00; 4 cycles total. With f7b5 = 1 → 001. addi with f7b5 = 1 → 000.
- lw with mem_ready held low 3 cycles in MEMREAD → mem_req and AdrSrc = 1 held; MEMWB follows the ready cycle; 8 cycles total.
- beq with Zero = 1 → PCSrc = 1; bne with Zero = 1 → PCSrc = 0; instr_retired pulses exactly once per instruction.
- R-type with funct3 001 → TRAP; trap stays 1, no RegWrite. WAIT_LIMIT = 4 with mem_ready = 0 in FETCH → TRAP after 4 cycles.
- CTRL_PERF_EN defined: after three back-to-back add instructions, instret_count = 3 and cycle_count = 12.
